// File: rtl/uart_rx_if.sv
// Host-side receive interface: one-entry holding register with valid/ack
// handshake and per-byte status.
interface uart_rx_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;

    // Receiver side: presents the byte and its status, takes the ack.
    modport master (
        output rx_data,
        output rx_valid,
        output parity_err,
        output frame_err,
        output overrun,
        input  rx_ack
    );

    // Consumer side: reads the byte and status, returns the ack.
    modport slave (
        input  rx_data,
        input  rx_valid,
        input  parity_err,
        input  frame_err,
        input  overrun,
        output rx_ack
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: start bit, 8 data bits LSB-first, parity bit, 1 or 2 stop
// bits. Each bit is sampled once at its centre. The received byte and its
// status land in a one-entry holding register with a valid/ack handshake.
module uart_rx #(
    parameter int unsigned BAUD_DIVISOR = 868,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     Rx_in,
    input  logic     Rx_en,
    input  logic     Two_stop,
    input  logic     Odd_parity,
    uart_rx_if.master rx_bus
);

    // Counter reloads: a full bit period, and half a bit to land on the
    // centre of the start bit.
    localparam logic [13:0] BAUD_RELOAD = 14'(BAUD_DIVISOR - 1);
    localparam logic [13:0] HALF_RELOAD = 14'((BAUD_DIVISOR / 2) - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP1  = 3'd4,
        STOP2  = 3'd5
    } state_t;

    // Parity mismatch: data XOR received parity bit XOR odd-mode flag is 1
    // exactly when the received parity bit is wrong.
    function automatic logic parity_mismatch(input logic [7:0] data,
                                             input logic       pbit,
                                             input logic       odd);
        return (^data) ^ pbit ^ odd;
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;

    logic [SYNC_STAGES-1:0] sync_r;
    logic             prev_r;
    logic             line_s;
    logic             fall_s;

    logic [13:0]      cnt_r;
    logic             sample_s;
    logic [2:0]       bit_cnt_r;
    logic [7:0]       shift_r;
    logic             two_stop_r;
    logic             odd_r;
    logic             perr_r;
    logic             ferr_r;

    logic             start_s;
    logic             start_ok_s;
    logic             shift_en_s;
    logic             parity_en_s;
    logic             stop1_en_s;
    logic             complete_s;
    logic             ferr_fin_s;

    logic [7:0]       rx_data_r;
    logic             rx_valid_r;
    logic             parity_err_r;
    logic             frame_err_r;
    logic             overrun_r;

    assign line_s   = sync_r[SYNC_STAGES-1];
    assign fall_s   = prev_r & ~line_s;
    assign sample_s = (state_r != IDLE) && (cnt_r == 14'd0);

    // Metastability synchroniser for Rx_in plus one flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= '1;
            prev_r <= 1'b1;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], Rx_in};
            prev_r <= line_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic: advance on each sample point.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (fall_s && Rx_en) begin
                    state_nxt_s = START;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            START: begin
                if (sample_s) begin
                    state_nxt_s = line_s ? IDLE : DATA;
                end else begin
                    state_nxt_s = START;
                end
            end
            DATA: begin
                if (sample_s && (bit_cnt_r == 3'd7)) begin
                    state_nxt_s = PARITY;
                end else begin
                    state_nxt_s = DATA;
                end
            end
            PARITY: begin
                if (sample_s) begin
                    state_nxt_s = STOP1;
                end else begin
                    state_nxt_s = PARITY;
                end
            end
            STOP1: begin
                if (sample_s) begin
                    state_nxt_s = two_stop_r ? STOP2 : IDLE;
                end else begin
                    state_nxt_s = STOP1;
                end
            end
            STOP2: begin
                if (sample_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = STOP2;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM outputs: one-cycle datapath strobes derived from state and sample.
    always_comb begin
        start_s     = 1'b0;
        start_ok_s  = 1'b0;
        shift_en_s  = 1'b0;
        parity_en_s = 1'b0;
        stop1_en_s  = 1'b0;
        complete_s  = 1'b0;
        ferr_fin_s  = ferr_r;
        case (state_r)
            IDLE: begin
                start_s = fall_s & Rx_en;
            end
            START: begin
                start_ok_s = sample_s & ~line_s;
            end
            DATA: begin
                shift_en_s = sample_s;
            end
            PARITY: begin
                parity_en_s = sample_s;
            end
            STOP1: begin
                stop1_en_s = sample_s;
                complete_s = sample_s & ~two_stop_r;
                ferr_fin_s = ~line_s;
            end
            STOP2: begin
                complete_s = sample_s;
                ferr_fin_s = ferr_r | ~line_s;
            end
            default: begin
                complete_s = 1'b0;
            end
        endcase
    end

    // Baud counter: half-bit load on start, then full-bit reloads at each
    // sample point; parked at zero while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= 14'd0;
        end else if (start_s) begin
            cnt_r <= HALF_RELOAD;
        end else if (state_r == IDLE) begin
            cnt_r <= 14'd0;
        end else if (cnt_r == 14'd0) begin
            cnt_r <= BAUD_RELOAD;
        end else begin
            cnt_r <= cnt_r - 14'd1;
        end
    end

    // Frame datapath: per-frame mode latch, bit counter, shift register and
    // running error bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            two_stop_r <= 1'b0;
            odd_r      <= 1'b0;
            bit_cnt_r  <= 3'd0;
            shift_r    <= 8'h00;
            perr_r     <= 1'b0;
            ferr_r     <= 1'b0;
        end else begin
            if (start_s) begin
                two_stop_r <= Two_stop;
                odd_r      <= Odd_parity;
            end else begin
                two_stop_r <= two_stop_r;
                odd_r      <= odd_r;
            end
            if (start_ok_s) begin
                bit_cnt_r <= 3'd0;
            end else if (shift_en_s) begin
                bit_cnt_r <= bit_cnt_r + 3'd1;
            end else begin
                bit_cnt_r <= bit_cnt_r;
            end
            if (shift_en_s) begin
                shift_r <= {line_s, shift_r[7:1]};
            end else begin
                shift_r <= shift_r;
            end
            if (parity_en_s) begin
                perr_r <= parity_mismatch(shift_r, line_s, odd_r);
            end else begin
                perr_r <= perr_r;
            end
            if (stop1_en_s) begin
                ferr_r <= ~line_s;
            end else begin
                ferr_r <= ferr_r;
            end
        end
    end

    // Holding register: load on completion (flagging overrun if the previous
    // byte was never taken), clear on ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data_r    <= 8'h00;
            rx_valid_r   <= 1'b0;
            parity_err_r <= 1'b0;
            frame_err_r  <= 1'b0;
            overrun_r    <= 1'b0;
        end else if (complete_s) begin
            rx_data_r    <= shift_r;
            rx_valid_r   <= 1'b1;
            parity_err_r <= perr_r;
            frame_err_r  <= ferr_fin_s;
            if (rx_valid_r && !rx_bus.rx_ack) begin
                overrun_r <= 1'b1;
            end else if (rx_bus.rx_ack) begin
                overrun_r <= 1'b0;
            end else begin
                overrun_r <= overrun_r;
            end
        end else if (rx_bus.rx_ack && rx_valid_r) begin
            rx_data_r    <= rx_data_r;
            rx_valid_r   <= 1'b0;
            parity_err_r <= 1'b0;
            frame_err_r  <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            rx_data_r    <= rx_data_r;
            rx_valid_r   <= rx_valid_r;
            parity_err_r <= parity_err_r;
            frame_err_r  <= frame_err_r;
            overrun_r    <= overrun_r;
        end
    end

    assign rx_bus.rx_data    = rx_data_r;
    assign rx_bus.rx_valid   = rx_valid_r;
    assign rx_bus.parity_err = parity_err_r;
    assign rx_bus.frame_err  = frame_err_r;
    assign rx_bus.overrun    = overrun_r;

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx at 16 clocks per bit.
module tb_uart_rx;

    logic clk;
    logic rst_n;
    logic Rx_in;
    logic Rx_en;
    logic Two_stop;
    logic Odd_parity;
    int   errors;
    int   checks;
    int   rise;

    uart_rx_if bus ();

    uart_rx #(.BAUD_DIVISOR(16), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Rx_in      (Rx_in),
        .Rx_en      (Rx_en),
        .Two_stop   (Two_stop),
        .Odd_parity (Odd_parity),
        .rx_bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one frame starting at a falling clock edge, one bit per 16
    // cycles. rise = cycle (after the start edge) at which rx_valid is first
    // seen high, -1 if never. rx_ack is held high for cycle ack_cyc only.
    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic two,
                              input logic s2, input int ack_cyc, output int rise_o);
        logic [11:0] bits;
        int nbits;
        bits   = {s2, 1'b1, pbit, d, 1'b0};
        nbits  = two ? 12 : 11;
        rise_o = -1;
        for (int c = 0; c < nbits * 16; c++) begin
            Rx_in      = bits[c / 16];
            bus.rx_ack = (c == ack_cyc);
            @(negedge clk);
            if (rise_o < 0 && bus.rx_valid === 1'b1) rise_o = c + 1;
        end
        bus.rx_ack = 1'b0;
        Rx_in      = 1'b1;
    endtask

    task automatic ack_pulse();
        bus.rx_ack = 1'b1;
        @(negedge clk);
        bus.rx_ack = 1'b0;
    endtask

    task automatic idle(input int n);
        Rx_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [7:0] fb;
        errors     = 0;
        checks     = 0;
        rst_n      = 1'b0;
        Rx_in      = 1'b1;
        Rx_en      = 1'b1;
        Two_stop   = 1'b0;
        Odd_parity = 1'b0;
        bus.rx_ack = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values
        chk("rst_data",   32'(bus.rx_data),    32'h00);
        chk("rst_valid",  32'(bus.rx_valid),   32'h0);
        chk("rst_perr",   32'(bus.parity_err), 32'h0);
        chk("rst_ferr",   32'(bus.frame_err),  32'h0);
        chk("rst_ovr",    32'(bus.overrun),    32'h0);
        rst_n = 1'b1;
        idle(5);

        // 0xA5, even parity (bit 0), one stop bit
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, -1, rise);
        chk("a5_rise",  32'(rise),           32'd171);
        chk("a5_data",  32'(bus.rx_data),    32'hA5);
        chk("a5_valid", 32'(bus.rx_valid),   32'h1);
        chk("a5_perr",  32'(bus.parity_err), 32'h0);
        chk("a5_ferr",  32'(bus.frame_err),  32'h0);
        ack_pulse();
        chk("a5_ack_valid", 32'(bus.rx_valid), 32'h0);
        idle(10);

        // 0x3C, odd parity, parity bit sent wrong (0)
        Odd_parity = 1'b1;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, -1, rise);
        Odd_parity = 1'b0;
        chk("3c_data",  32'(bus.rx_data),    32'h3C);
        chk("3c_valid", 32'(bus.rx_valid),   32'h1);
        chk("3c_perr",  32'(bus.parity_err), 32'h1);
        chk("3c_ferr",  32'(bus.frame_err),  32'h0);
        ack_pulse();
        chk("3c_ack_valid", 32'(bus.rx_valid),   32'h0);
        chk("3c_ack_perr",  32'(bus.parity_err), 32'h0);
        idle(10);

        // 0x81, two stop bits, even parity correct (0), second stop bit 0
        Two_stop = 1'b1;
        send_frame(8'h81, 1'b0, 1'b1, 1'b0, -1, rise);
        Two_stop = 1'b0;
        chk("81_rise",  32'(rise),           32'd187);
        chk("81_data",  32'(bus.rx_data),    32'h81);
        chk("81_perr",  32'(bus.parity_err), 32'h0);
        chk("81_ferr",  32'(bus.frame_err),  32'h1);
        ack_pulse();
        chk("81_ack_ferr", 32'(bus.frame_err), 32'h0);
        idle(20);

        // False start: 4 low cycles then high
        Rx_in = 1'b0;
        repeat (4) @(negedge clk);
        idle(30);
        chk("fs_valid", 32'(bus.rx_valid),   32'h0);
        chk("fs_perr",  32'(bus.parity_err), 32'h0);
        chk("fs_ferr",  32'(bus.frame_err),  32'h0);

        // Back-to-back 0x11 then 0x22 with no ack: overrun
        send_frame(8'h11, 1'b0, 1'b0, 1'b1, -1, rise);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1, -1, rise);
        chk("ovr_data",  32'(bus.rx_data),  32'h22);
        chk("ovr_valid", 32'(bus.rx_valid), 32'h1);
        chk("ovr_flag",  32'(bus.overrun),  32'h1);
        ack_pulse();
        chk("ovr_ack_valid", 32'(bus.rx_valid), 32'h0);
        chk("ovr_ack_flag",  32'(bus.overrun),  32'h0);
        idle(10);

        // Same again, with ack in the completion cycle of the second frame
        send_frame(8'h11, 1'b0, 1'b0, 1'b1, -1, rise);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1, 170, rise);
        chk("ackc_data",  32'(bus.rx_data),  32'h22);
        chk("ackc_valid", 32'(bus.rx_valid), 32'h1);
        chk("ackc_ovr",   32'(bus.overrun),  32'h0);
        idle(10);

        // Reset during data bit 3 of 0x5A (holding register still full)
        fb = 8'h5A;
        for (int c = 0; c < 72; c++) begin
            Rx_in = (c < 16) ? 1'b0 : fb[(c / 16) - 1];
            @(negedge clk);
        end
        rst_n = 1'b0;
        @(negedge clk);
        chk("mrst_data",  32'(bus.rx_data),  32'h00);
        chk("mrst_valid", 32'(bus.rx_valid), 32'h0);
        chk("mrst_ovr",   32'(bus.overrun),  32'h0);
        idle(3);
        rst_n = 1'b1;
        idle(200);
        chk("mrst_quiet", 32'(bus.rx_valid), 32'h0);

        // Clean frame 0xC3 after reset
        send_frame(8'hC3, 1'b0, 1'b0, 1'b1, -1, rise);
        chk("c3_rise",  32'(rise),           32'd171);
        chk("c3_data",  32'(bus.rx_data),    32'hC3);
        chk("c3_perr",  32'(bus.parity_err), 32'h0);
        chk("c3_ferr",  32'(bus.frame_err),  32'h0);
        chk("c3_ovr",   32'(bus.overrun),    32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver, the receive-side counterpart of the team's UART transmitter; decodes the same frame format on a single serial line.
- Frame: start bit (0), 8 data bits LSB-first, 1 parity bit (always present), then 1 or 2 stop bits (1).
- Delivers each byte into a one-entry holding register with valid/ack handshake, parity/frame/overrun status. Sits between the pad-side Rx pin and the host-side consumer.

Parameters:
- BAUD_DIVISOR, 868, clk cycles per bit; legal range 4..16383; baud counter is 14 bits.
- SYNC_STAGES, 2, flops in the Rx_in synchroniser; minimum 2.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset; asynchronous, active-low
- Rx_in  input  1  serial line, asynchronous to clk, idle high
- Rx_en  input  1  receiver enable; sampled only in IDLE
- Two_stop  input  1  1 = two stop bits expected
- Odd_parity  input  1  1 = odd parity, 0 = even parity
- rx_ack  input  1  consumer takes rx_data this cycle
- rx_data  output  8  received byte
- rx_valid  output  1  holding register full
- parity_err  output  1  parity mismatch for byte in rx_data
- frame_err  output  1  stop-bit error for byte in rx_data
- overrun  output  1  sticky: a byte was overwritten before ack

Behaviour:
- Reset: rx_data=0x00, rx_valid=0, parity_err=0, frame_err=0, overrun=0; synchroniser flops=1; FSM=IDLE; counters=0.
- Synchroniser: Rx_in through SYNC_STAGES flops, plus one extra flop for edge detect; falling edge = previous 1 and current 0.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
- IDLE: on falling edge and Rx_en=1, go START. Load baud counter with BAUD_DIVISOR/2-1 (integer division). Latch Two_stop and Odd_parity for the whole frame.
- Sample point: the cycle the baud counter equals 0. The counter then reloads BAUD_DIVISOR-1; otherwise it decrements.
- START: at the sample point, line=0 goes to DATA with bit counter=0. Line=1 is a false start: go to IDLE, no output, no flags.
- DATA: at each sample point, shift the sampled bit into bit 7 of the shift register (LSB-first). After the 8th sample (bit counter 7) go to PARITY.
- PARITY: at the sample point, perr = (^data) ^ sampled_bit ^ Odd_parity_latched. Go to STOP1.
- STOP1: at the sample point, ferr = (sample==0). If Two_stop_latched, go to STOP2; else complete.
- STOP2: at the sample point, ferr |= (sample==0); complete.
- Complete (same cycle as the final stop sample):
  - next cycle rx_data=byte, rx_valid=1, parity_err=perr, frame_err=ferr; FSM returns to IDLE.
  - No wait for end of stop bit, so a back-to-back start edge is caught.
  - Bytes with errors are still delivered, with the error flags set.
- Handshake:
  - rx_ack with rx_valid=1 and no completion: rx_valid=0 next cycle. parity_err, frame_err and overrun clear with it.
  - rx_ack with rx_valid=0 is ignored.
- Overrun:
  - Completion while rx_valid=1 and rx_ack=0: new byte and flags overwrite the register and overrun sets to 1.
  - Completion in the same cycle as rx_ack: new byte loads, rx_valid stays 1, overrun=0.
- Break or stuck-low line: frame_err is reported once. No new frame starts until the line returns high and a fresh falling edge occurs.
- Rx_en deasserted mid-frame: the current frame completes normally; no new start is accepted.
- Two_stop and Odd_parity changes mid-frame have no effect until the next start.
- Reset asserted mid-frame: immediate return to reset values; the partial byte is discarded.

Test Plan:
- Use BAUD_DIVISOR=16 throughout.
- Even parity, 1 stop, byte 0xA5 with parity bit 0 -> rx_data=0xA5, rx_valid=1, parity_err=0, frame_err=0. rx_valid rises 1 cycle after the STOP1 sample (start-sample + 10×16 cycles).
- Odd_parity=1, byte 0x3C sent with parity bit 0 (wrong; correct is 1) -> rx_data=0x3C, parity_err=1, frame_err=0. rx_ack clears rx_valid and parity_err next cycle.
- Two_stop=1, byte 0x81, correct parity, second stop bit driven 0 -> frame_err=1. rx_valid does not rise until the STOP2 sample.
- Rx_in low for 4 cycles (less than 8), then high -> FSM back in IDLE after the START sample; rx_valid stays 0; no flags set.
- Back-to-back frames 0x11 then 0x22, no ack -> rx_data=0x22, rx_valid=1, overrun=1. rx_ack -> all flags cleared. Repeat with rx_ack in the completion cycle -> overrun=0.
- rst_n pulsed low during DATA bit 3 of 0x5A -> outputs at reset values. A following clean frame 0xC3 is received correctly.
